// File: rtl/sm_sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : sm_sat_accum
// Description : Multi-lane sign-magnitude saturating accumulator for the
//               Mode7 affine stepping path. Each lane holds one running
//               coordinate that is loaded once per scanline and then stepped
//               by signed deltas. Adds clamp at the largest magnitude instead
//               of wrapping. Commands arrive on a valid/ready handshake and
//               every accepted command returns one registered result beat.
//
// Parameters  : WIDTH - lane word width including sign bit (>= 4)
//               LANES - number of independent accumulator lanes
//
// Ports       : clk        - system clock (rising edge)
//               rst        - synchronous active-high reset
//               in_valid   - command present
//               in_ready   - command accepted when in_valid && in_ready
//               in_op      - 00 NOP, 01 LOAD, 10 ADD, 11 CLEAR
//               in_data    - per-lane operand, lane i at [i*WIDTH +: WIDTH]
//               out_valid  - result beat present
//               out_ready  - result consumed when out_valid && out_ready
//               out_data   - per-lane accumulator value after the command
//               out_sat    - per-lane sticky saturation flag
//               out_satcnt - per-lane 8-bit saturation event counter
//                            (only when SM_SAT_ACCUM_SATCNT_EN is defined)
//
// Options     : SM_SAT_ACCUM_SATCNT_EN - adds out_satcnt and its counters
//
// Revision    : 1.0 - initial release
// ============================================================================
module sm_sat_accum #(
    parameter int WIDTH = 24,
    parameter int LANES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [LANES*WIDTH-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
`ifdef SM_SAT_ACCUM_SATCNT_EN
    output logic [LANES*8-1:0]       out_satcnt,
`endif
    output logic [LANES-1:0]         out_sat
);

    localparam int             c_M       = WIDTH - 1;
    localparam logic [c_M-1:0] c_MAXMAG  = '1;
    localparam logic [1:0]     c_OP_NOP   = 2'b00;
    localparam logic [1:0]     c_OP_LOAD  = 2'b01;
    localparam logic [1:0]     c_OP_ADD   = 2'b10;
    localparam logic [1:0]     c_OP_CLEAR = 2'b11;

    // The accumulators only change on an accepted command, which is exactly
    // when the output beat is reloaded, so the accumulator registers double
    // as the registered output data.
    logic                    r_out_valid;
    logic [LANES*WIDTH-1:0]  r_acc;
    logic [LANES-1:0]        r_sat;
    logic [LANES*WIDTH-1:0]  w_acc_next;
    logic [LANES-1:0]        w_sat_next;
    logic                    w_accept;
`ifdef SM_SAT_ACCUM_SATCNT_EN
    logic [LANES*8-1:0]      r_cnt;
    logic [LANES*8-1:0]      w_cnt_next;
`endif

    assign in_ready = !rst && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [c_M-1:0]   w_am;
            logic [c_M-1:0]   w_bm;
            logic             w_as;
            logic             w_bs;
            logic [c_M:0]     w_sum;
            logic [c_M-1:0]   w_res_mag;
            logic             w_res_sign;
            logic             w_ovf;
            logic [WIDTH-1:0] w_lane_next;
            logic             w_sat_lane;

            // Negative zero on either operand is folded to +0 here so the
            // sign comparison below never sees it.
            assign w_am  = r_acc[gi*WIDTH +: c_M];
            assign w_as  = r_acc[gi*WIDTH + c_M] && (w_am != '0);
            assign w_bm  = in_data[gi*WIDTH +: c_M];
            assign w_bs  = in_data[gi*WIDTH + c_M] && (w_bm != '0);
            // One extra bit: the carry out is the overflow indication.
            assign w_sum = {1'b0, w_am} + {1'b0, w_bm};

            always_comb begin
                w_res_mag  = '0;
                w_res_sign = 1'b0;
                w_ovf      = 1'b0;
                if (w_as == w_bs) begin
                    w_res_sign = w_as;
                    if (w_sum[c_M]) begin
                        w_res_mag = c_MAXMAG;
                        w_ovf     = 1'b1;
                    end else begin
                        w_res_mag = w_sum[c_M-1:0];
                    end
                end else if (w_am >= w_bm) begin
                    w_res_mag  = w_am - w_bm;
                    w_res_sign = w_as;
                end else begin
                    w_res_mag  = w_bm - w_am;
                    w_res_sign = w_bs;
                end
                // Cancellation must never present negative zero.
                if (w_res_mag == '0) begin
                    w_res_sign = 1'b0;
                end
            end

            always_comb begin
                w_lane_next = r_acc[gi*WIDTH +: WIDTH];
                w_sat_lane  = r_sat[gi];
                case (in_op)
                    c_OP_NOP: begin
                    end
                    c_OP_LOAD: begin
                        w_lane_next = {w_bs, w_bm};
                        w_sat_lane  = 1'b0;
                    end
                    c_OP_ADD: begin
                        w_lane_next = {w_res_sign, w_res_mag};
                        w_sat_lane  = r_sat[gi] | w_ovf;
                    end
                    c_OP_CLEAR: begin
                        w_lane_next = '0;
                        w_sat_lane  = 1'b0;
                    end
                    default: begin
                    end
                endcase
            end

            assign w_acc_next[gi*WIDTH +: WIDTH] = w_lane_next;
            assign w_sat_next[gi]                = w_sat_lane;

`ifdef SM_SAT_ACCUM_SATCNT_EN
            logic [7:0] w_cnt_cur;
            logic [7:0] w_cnt_lane;

            assign w_cnt_cur = r_cnt[gi*8 +: 8];

            always_comb begin
                w_cnt_lane = w_cnt_cur;
                case (in_op)
                    c_OP_LOAD, c_OP_CLEAR: w_cnt_lane = 8'd0;
                    c_OP_ADD: begin
                        // Counts overflow events, pinned at full scale.
                        if (w_ovf && (w_cnt_cur != 8'hFF)) begin
                            w_cnt_lane = w_cnt_cur + 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            assign w_cnt_next[gi*8 +: 8] = w_cnt_lane;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_sat       <= '0;
`ifdef SM_SAT_ACCUM_SATCNT_EN
            r_cnt       <= '0;
`endif
        end else if (w_accept) begin
            // Covers accept-and-drain in one cycle: new beat replaces old.
            r_out_valid <= 1'b1;
            r_acc       <= w_acc_next;
            r_sat       <= w_sat_next;
`ifdef SM_SAT_ACCUM_SATCNT_EN
            r_cnt       <= w_cnt_next;
`endif
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_sat   = r_sat;
`ifdef SM_SAT_ACCUM_SATCNT_EN
    assign out_satcnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm_sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_sat_accum
// Description : Self-checking bench for sm_sat_accum (WIDTH=24, LANES=2).
//               A signed-integer reference model produces the expected beat
//               for each accepted command; beats are compared in order as
//               they are consumed. Scenario tasks add direct checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_sat_accum;

    localparam int  W      = 24;
    localparam int  L      = 2;
    localparam longint MAXMAG = (longint'(1) << (W - 1)) - 1;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_op;
    logic [L*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] out_data;
    logic [L-1:0]   out_sat;
`ifdef SM_SAT_ACCUM_SATCNT_EN
    logic [L*8-1:0] out_satcnt;
`endif

    int checks = 0;
    int errors = 0;

    sm_sat_accum #(.WIDTH(W), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SM_SAT_ACCUM_SATCNT_EN
        .out_satcnt(out_satcnt),
`endif
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [W-1:0]   m_acc [L];
    logic [L-1:0]   m_sat;
    int             m_cnt [L];
    logic [L*W-1:0] q_data [$];
    logic [L-1:0]   q_sat  [$];
    logic [L*8-1:0] q_cnt  [$];

    function automatic longint to_int(input logic [W-1:0] v);
        longint r;
        r = longint'(v[W-2:0]);
        if (v[W-1]) r = -r;
        return r;
    endfunction

    function automatic logic [W-1:0] from_int(input longint v);
        logic [W-1:0] r;
        if (v < 0) r = {1'b1, (W-1)'(-v)};
        else       r = {1'b0, (W-1)'(v)};
        return r;
    endfunction

    task automatic model_cmd(input logic [1:0] op, input logic [L*W-1:0] d);
        longint s;
        logic [L*W-1:0] pd;
        logic [L*8-1:0] pc;
        for (int l = 0; l < L; l++) begin
            case (op)
                OP_LOAD: begin
                    m_acc[l] = from_int(to_int(d[l*W +: W]));
                    m_sat[l] = 1'b0;
                    m_cnt[l] = 0;
                end
                OP_CLEAR: begin
                    m_acc[l] = '0;
                    m_sat[l] = 1'b0;
                    m_cnt[l] = 0;
                end
                OP_ADD: begin
                    s = to_int(m_acc[l]) + to_int(d[l*W +: W]);
                    if (s > MAXMAG || s < -MAXMAG) begin
                        s = (s > 0) ? MAXMAG : -MAXMAG;
                        m_sat[l] = 1'b1;
                        if (m_cnt[l] < 255) m_cnt[l]++;
                    end
                    m_acc[l] = from_int(s);
                end
                default: begin
                end
            endcase
        end
        for (int l = 0; l < L; l++) begin
            pd[l*W +: W] = m_acc[l];
            pc[l*8 +: 8] = 8'(m_cnt[l]);
        end
        q_data.push_back(pd);
        q_sat.push_back(m_sat);
        q_cnt.push_back(pc);
    endtask

    // Inputs change #1 after posedge, so at negedge they describe what the
    // next rising edge will do: retire the current beat, accept a command.
    always @(negedge clk) begin
        logic [L*W-1:0] ed;
        logic [L-1:0]   es;
        logic [L*8-1:0] ec;
        if (rst) begin
            q_data.delete();
            q_sat.delete();
            q_cnt.delete();
            for (int l = 0; l < L; l++) begin
                m_acc[l] = '0;
                m_cnt[l] = 0;
            end
            m_sat = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %h with no beat expected", out_data);
                end else begin
                    ed = q_data.pop_front();
                    es = q_sat.pop_front();
                    ec = q_cnt.pop_front();
                    checks++;
                    if (out_data !== ed) begin
                        errors++;
                        $display("FAIL beat_data: got %h expected %h", out_data, ed);
                    end
                    checks++;
                    if (out_sat !== es) begin
                        errors++;
                        $display("FAIL beat_sat: got %b expected %b", out_sat, es);
                    end
`ifdef SM_SAT_ACCUM_SATCNT_EN
                    checks++;
                    if (out_satcnt !== ec) begin
                        errors++;
                        $display("FAIL beat_satcnt: got %h expected %h", out_satcnt, ec);
                    end
`endif
                end
            end
            if (in_valid && in_ready) model_cmd(in_op, in_data);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic issue(input logic [1:0] op, input logic [W-1:0] l0, input logic [W-1:0] l1);
        bit ok;
        ok       = 1'b0;
        in_op    = op;
        in_data  = {l1, l0};
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_timeout: in_ready stayed 0, expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout: out_valid stayed 1, expected 0 within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h s=%b expected v=0 d=0 s=0",
                     out_valid, out_data, out_sat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_load_add();
        out_ready = 1'b1;
        issue(OP_LOAD, 24'h000010, 24'h800010);
        issue(OP_ADD,  24'h800030, 24'h000030);
        drain();
        checks++;
        if (out_data !== {24'h000020, 24'h800020} || out_sat !== 2'b00) begin
            errors++;
            $display("FAIL load_add: got %h sat %b expected 000020800020 sat 00", out_data, out_sat);
        end
    endtask

    task automatic test_saturate();
        issue(OP_LOAD, 24'h7FFFF0, 24'hFFFFF0);
        issue(OP_ADD,  24'h000020, 24'h800020);
        drain();
        checks++;
        if (out_data !== {24'hFFFFFF, 24'h7FFFFF} || out_sat !== 2'b11) begin
            errors++;
            $display("FAIL saturate: got %h sat %b expected FFFFFF7FFFFF sat 11", out_data, out_sat);
        end
        issue(OP_ADD, 24'h800001, 24'h000001);
        drain();
        checks++;
        if (out_data !== {24'hFFFFFE, 24'h7FFFFE} || out_sat !== 2'b11) begin
            errors++;
            $display("FAIL sat_sticky: got %h sat %b expected FFFFFE7FFFFE sat 11", out_data, out_sat);
        end
        issue(OP_CLEAR, 24'h123456, 24'h654321);
        drain();
        checks++;
        if (out_data !== '0 || out_sat !== 2'b00) begin
            errors++;
            $display("FAIL clear: got %h sat %b expected 0 sat 00", out_data, out_sat);
        end
    endtask

    task automatic test_neg_zero();
        issue(OP_LOAD, 24'h000005, 24'h800000);
        issue(OP_ADD,  24'h800005, 24'h800000);
        issue(OP_NOP,  24'h800007, 24'h000009);
        drain();
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL neg_zero: got %h expected 000000000000", out_data);
        end
    endtask

    task automatic test_back_to_back();
        int             accepted;
        int             beats;
        bit             have;
        logic [L*W-1:0] held;
        accepted  = 0;
        beats     = 0;
        have      = 1'b0;
        held      = '0;
        out_ready = 1'b0;
        in_op     = OP_ADD;
        in_data   = {24'h000001, 24'h000001};
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_valid && in_ready) accepted++;
            if (out_valid) begin
                if (!have) begin
                    held = out_data;
                    have = 1'b1;
                end else begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL hold_stable: got %h expected %h", out_data, held);
                    end
                end
            end
        end
        checks++;
        if (accepted != 1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure: got accepted=%0d in_ready=%b expected 1 and 0",
                     accepted, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid && in_ready) beats++;
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL throughput: got %0d beats expected 8", beats);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_inflight();
        out_ready = 1'b0;
        issue(OP_ADD, 24'h000004, 24'h800002);
        in_op    = OP_ADD;
        in_data  = {24'h000007, 24'h000007};
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0) begin
            errors++;
            $display("FAIL reset_inflight: got v=%b d=%h s=%b expected v=0 d=0 s=0",
                     out_valid, out_data, out_sat);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        issue(OP_ADD, 24'h000003, 24'h000003);
        drain();
        checks++;
        if (out_data !== {24'h000003, 24'h000003}) begin
            errors++;
            $display("FAIL post_reset_add: got %h expected 000003000003", out_data);
        end
    endtask

`ifdef SM_SAT_ACCUM_SATCNT_EN
    task automatic test_satcnt();
        out_ready = 1'b1;
        issue(OP_LOAD, 24'h7FFFFF, 24'h000000);
        for (int i = 0; i < 300; i++) issue(OP_ADD, 24'h000001, 24'h000000);
        drain();
        checks++;
        if (out_satcnt !== {8'd0, 8'd255}) begin
            errors++;
            $display("FAIL satcnt_cap: got %h expected 00FF", out_satcnt);
        end
        issue(OP_LOAD, 24'h000001, 24'h000001);
        drain();
        checks++;
        if (out_satcnt !== '0) begin
            errors++;
            $display("FAIL satcnt_load: got %h expected 0000", out_satcnt);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1000000, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = OP_NOP;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_load_add();
        test_saturate();
        test_neg_zero();
        test_back_to_back();
        test_reset_inflight();
`ifdef SM_SAT_ACCUM_SATCNT_EN
        test_satcnt();
`endif
        checks++;
        if (q_data.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending beats expected 0", q_data.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
